instruction_fetch_stage: RTL

Fetch stage directly upstream of the decode stage. It generates the fetch PC and issues word requests to instruction memory, buffering returned words in a small prefetch FIFO. Each cycle it presents one instruction, its PC and predecoded branch/immediate controls to decode. On a taken branch or jump from EX it flushes its contents and redirects to the target.

---
 rtl/instruction_fetch_stage_pkg.sv | 42 ++++
 rtl/instruction_fetch_stage_predecoder.sv | 29 ++
 rtl/instruction_fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        BJ_NONE   = 2'b00,
        BJ_BRANCH = 2'b01,
        BJ_JAL    = 2'b10,
        BJ_JALR   = 2'b11
    } bj_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;

    // addi x0,x0,0 with the two always-one length bits stripped
    localparam logic [29:0] NOP_WORD = 30'h0000_0004;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [29:0] pc;
        logic [29:0] instr;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_predecoder.sv
// Opcode predecode of the outgoing fetch word into branch/jump class and immediate format.
module fetch_predecoder
    import instruction_fetch_stage_pkg::*;
(
    input  logic [4:0] opcode,
    output bj_op_e     branch_jump_op_c,
    output imm_src_e   imm_src_c
);

    always_comb begin
        branch_jump_op_c = BJ_NONE;
        imm_src_c        = IMM_I;
        case (opcode)
            OPC_BRANCH: begin
                branch_jump_op_c = BJ_BRANCH;
                imm_src_c        = IMM_B;
            end
            OPC_JAL: begin
                branch_jump_op_c = BJ_JAL;
                imm_src_c        = IMM_J;
            end
            OPC_JALR:           branch_jump_op_c = BJ_JALR;
            OPC_STORE:          imm_src_c = IMM_S;
            OPC_LUI, OPC_AUIPC: imm_src_c = IMM_U;
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC generation, single-outstanding imem requests, prefetch FIFO and
// registered instruction/predecode outputs toward decode.
module instruction_fetch_stage #(
    parameter logic [29:0] RESET_PC   = 30'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [29:0] NOP_WORD   = instruction_fetch_stage_pkg::NOP_WORD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        busywait_i,
    input  logic        branching_i,
    input  logic [29:0] branch_target_i,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic [29:0] instr_o,
    output logic [29:0] pc_o,
    output logic        valid_o,
    output logic        fault_o,
    output logic [1:0]  branch_jump_op_o,
    output logic [2:0]  imm_src_o
);
    import instruction_fetch_stage_pkg::*;

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_state_e     state_q, state_d;
    logic [29:0]      fetch_pc_q;
    fetch_entry_t     fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic         rsp_pending, outstanding_after, hold, fifo_empty;
    logic         issue, push, pop;
    fetch_entry_t head, rsp_entry;
    bj_op_e       pd_bj;
    imm_src_e     pd_imm;

    assign head = fifo_q[rd_ptr_q];

    fetch_predecoder u_predecoder (
        .opcode           (head.instr[4:0]),
        .branch_jump_op_c (pd_bj),
        .imm_src_c        (pd_imm)
    );

    // Issue/push/pop decisions and next state; reset and redirect both drop in-flight data
    always_comb begin
        rsp_pending       = (state_q != ST_REQ);
        outstanding_after = rsp_pending && !imem_rvalid_i;
        hold              = stall_i || busywait_i;
        fifo_empty        = (count_q == '0);
        issue             = (state_q == ST_REQ) && !branching_i && (count_q < CNT_W'(FIFO_DEPTH));
        push              = (state_q == ST_WAIT) && imem_rvalid_i && !branching_i;
        pop               = !branching_i && !hold && !fifo_empty;
        rsp_entry         = '{pc:    imem_addr_o,
                              instr: imem_rdata_i[31:2],
                              err:   imem_err_i || (imem_rdata_i[1:0] != 2'b11)};
        state_d           = state_q;
        if (rst_i || branching_i) begin
            if (outstanding_after) state_d = ST_FLUSH;
            else                   state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_REQ:            if (issue) state_d = ST_WAIT;
                ST_WAIT, ST_FLUSH: if (imem_rvalid_i) state_d = ST_REQ;
                default:           state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q       <= RESET_PC;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            imem_req_o       <= 1'b0;
            imem_addr_o      <= '0;
            instr_o          <= NOP_WORD;
            pc_o             <= '0;
            valid_o          <= 1'b0;
            fault_o          <= 1'b0;
            branch_jump_op_o <= BJ_NONE;
            imm_src_o        <= IMM_I;
        end else begin
            imem_req_o <= issue;
            if (branching_i) begin
                fetch_pc_q <= branch_target_i;
            end else if (issue) begin
                imem_addr_o <= fetch_pc_q;
                fetch_pc_q  <= fetch_pc_q + 30'd1;
            end

            if (branching_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr_q] <= rsp_entry;
                    wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end

            // Redirect beats hold; a same-cycle push is not bypassed to the outputs
            if (branching_i || (!hold && fifo_empty)) begin
                instr_o          <= NOP_WORD;
                pc_o             <= '0;
                valid_o          <= 1'b0;
                fault_o          <= 1'b0;
                branch_jump_op_o <= BJ_NONE;
                imm_src_o        <= IMM_I;
            end else if (pop) begin
                instr_o          <= head.instr;
                pc_o             <= head.pc;
                valid_o          <= 1'b1;
                fault_o          <= head.err;
                branch_jump_op_o <= head.err ? BJ_NONE : pd_bj;
                imm_src_o        <= head.err ? IMM_I : pd_imm;
            end
        end
    end

endmodule
